// File: rtl/jpeg_mcu_sequencer_if.sv
// Handshake, status and datapath-enable bundle between the JPEG MCU
// sequencer and the encoder datapath / block source around it.
// The master modport is the sequencer's view; slave is the environment's.
interface jpeg_mcu_sequencer_if;
   logic        start;
   logic [15:0] num_mcu;
   logic        blk_valid;
   logic        blk_ready;
   logic        huff_done;
   logic        input_enable;
   logic        dct_enable;
   logic        dct_end_enable;
   logic        zigzag_input_enable;
   logic        zigag_enable;
   logic        Huffman_start;
   logic [7:0]  matrix_row;
   logic        is_luminance;
   logic [1:0]  comp_id;
   logic        busy;
   logic        mcu_done;
   logic        frame_done;
   logic        huff_err;

   modport master (
      input  start, num_mcu, blk_valid, huff_done,
      output blk_ready, input_enable, dct_enable, dct_end_enable,
             zigzag_input_enable, zigag_enable, Huffman_start,
             matrix_row, is_luminance, comp_id, busy,
             mcu_done, frame_done, huff_err
   );

   modport slave (
      output start, num_mcu, blk_valid, huff_done,
      input  blk_ready, input_enable, dct_enable, dct_end_enable,
             zigzag_input_enable, zigag_enable, Huffman_start,
             matrix_row, is_luminance, comp_id, busy,
             mcu_done, frame_done, huff_err
   );
endinterface

// File: rtl/jpeg_mcu_sequencer.sv
// JPEG MCU sequencer: accepts 8x8 blocks and steps each one through
// load, DCT, capture, row-wise quantize/zigzag fill, zigzag scan and
// Huffman encode, grouping Y_BLOCKS luma + C_BLOCKS chroma blocks per MCU.
// Optional Huffman watchdog: define SEQ_HUFF_WATCHDOG_EN to compile it in.
module jpeg_mcu_sequencer #(
   parameter int DCT_LAT      = 8,
   parameter int Q_LAT        = 1,
   parameter int Y_BLOCKS     = 4,
   parameter int C_BLOCKS     = 2,
   parameter int HUFF_TIMEOUT = 1024
) (
   input logic                   clock,
   input logic                   reset,
   jpeg_mcu_sequencer_if.master  bus
);

   localparam int TOTAL = Y_BLOCKS + C_BLOCKS;
   localparam int DCT_W = (DCT_LAT > 1) ? $clog2(DCT_LAT) : 1;

   typedef enum logic [3:0] {
      IDLE, LOAD, DCT, CAPT, QROW, ZZ, HSTART, HWAIT, NEXT
   } state_t;

   state_t            state, state_n;
   logic [DCT_W-1:0]  dct_cnt, dct_cnt_n;
   logic [2:0]        row, row_n;
   logic [1:0]        sub, sub_n;
   logic [2:0]        blk_idx, blk_idx_n;
   logic [15:0]       mcu_cnt, mcu_cnt_n;
   logic              blk_last;
   logic              mcu_done_n, frame_done_n, huff_err_n;
   logic              is_lum_n;
   logic [1:0]        comp_n;
   logic [7:0]        row_out_n;

   logic              blk_ready_q, dct_en_q, capt_q, zzin_q, zz_q, hstart_q;
   logic              busy_q, mcu_done_q, frame_done_q, huff_err_q, is_lum_q;
   logic [1:0]        comp_q;
   logic [7:0]        row_q;

`ifdef SEQ_HUFF_WATCHDOG_EN
   localparam int WD_W = $clog2(HUFF_TIMEOUT + 1);
   logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
   logic              wd_expired;
   assign wd_expired = (wd_cnt == WD_W'(HUFF_TIMEOUT - 1));
`else
   logic              unused_timeout;
   assign unused_timeout = (HUFF_TIMEOUT > 0);
`endif

   assign blk_last = (blk_idx == 3'(TOTAL - 1));

   // Next-state, counter and pulse decode; outputs derived from the next state
   always_comb begin
      state_n      = state;
      dct_cnt_n    = dct_cnt;
      row_n        = row;
      sub_n        = sub;
      blk_idx_n    = blk_idx;
      mcu_cnt_n    = mcu_cnt;
      mcu_done_n   = 1'b0;
      frame_done_n = 1'b0;
      huff_err_n   = 1'b0;
`ifdef SEQ_HUFF_WATCHDOG_EN
      wd_cnt_n     = wd_cnt;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.num_mcu != 16'd0) begin
                  state_n   = LOAD;
                  mcu_cnt_n = bus.num_mcu;
                  blk_idx_n = 3'd0;
               end else begin
                  frame_done_n = 1'b1;
               end
            end
         end
         LOAD: begin
            if (bus.blk_valid && blk_ready_q) begin
               state_n   = DCT;
               dct_cnt_n = '0;
            end
         end
         DCT: begin
            if (dct_cnt == DCT_W'(DCT_LAT - 1)) state_n = CAPT;
            else dct_cnt_n = dct_cnt + 1'b1;
         end
         CAPT: begin
            state_n = QROW;
            row_n   = 3'd0;
            sub_n   = 2'd0;
         end
         QROW: begin
            if (sub == 2'(Q_LAT)) begin
               sub_n = 2'd0;
               if (row == 3'd7) state_n = ZZ;
               else row_n = row + 3'd1;
            end else begin
               sub_n = sub + 2'd1;
            end
         end
         ZZ: state_n = HSTART;
         HSTART: begin
            state_n = HWAIT;
`ifdef SEQ_HUFF_WATCHDOG_EN
            wd_cnt_n = '0;
`endif
         end
         HWAIT: begin
            if (bus.huff_done) begin
               state_n    = NEXT;
               mcu_done_n = blk_last;
            end
`ifdef SEQ_HUFF_WATCHDOG_EN
            else if (wd_expired) begin
               state_n    = NEXT;
               mcu_done_n = blk_last;
               huff_err_n = 1'b1;
            end else begin
               wd_cnt_n = wd_cnt + 1'b1;
            end
`endif
         end
         NEXT: begin
            state_n = LOAD;
            if (blk_last) begin
               blk_idx_n = 3'd0;
               mcu_cnt_n = mcu_cnt - 16'd1;
               if (mcu_cnt == 16'd1) begin
                  state_n      = IDLE;
                  frame_done_n = 1'b1;
               end
            end else begin
               blk_idx_n = blk_idx + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      is_lum_n  = 1'b0;
      comp_n    = 2'd0;
      row_out_n = 8'd0;
      if (state_n != IDLE && state_n != NEXT) begin
         if (blk_idx_n < 3'(Y_BLOCKS)) is_lum_n = 1'b1;
         else if (blk_idx_n == 3'(Y_BLOCKS)) comp_n = 2'd1;
         else comp_n = 2'd2;
      end
      if (state_n == QROW) row_out_n = {5'd0, row_n};
   end

   // State and counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         dct_cnt <= '0;
         row     <= 3'd0;
         sub     <= 2'd0;
         blk_idx <= 3'd0;
         mcu_cnt <= 16'd0;
`ifdef SEQ_HUFF_WATCHDOG_EN
         wd_cnt  <= '0;
`endif
      end else begin
         state   <= state_n;
         dct_cnt <= dct_cnt_n;
         row     <= row_n;
         sub     <= sub_n;
         blk_idx <= blk_idx_n;
         mcu_cnt <= mcu_cnt_n;
`ifdef SEQ_HUFF_WATCHDOG_EN
         wd_cnt  <= wd_cnt_n;
`endif
      end
   end

   // Registered datapath enables and status, aligned with the state they belong to
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blk_ready_q  <= 1'b0;
         dct_en_q     <= 1'b0;
         capt_q       <= 1'b0;
         zzin_q       <= 1'b0;
         zz_q         <= 1'b0;
         hstart_q     <= 1'b0;
         busy_q       <= 1'b0;
         mcu_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         huff_err_q   <= 1'b0;
         is_lum_q     <= 1'b0;
         comp_q       <= 2'd0;
         row_q        <= 8'd0;
      end else begin
         blk_ready_q  <= (state_n == LOAD);
         dct_en_q     <= (state_n == DCT);
         capt_q       <= (state_n == CAPT);
         zzin_q       <= (state_n == QROW) && (sub_n == 2'(Q_LAT));
         zz_q         <= (state_n == ZZ);
         hstart_q     <= (state_n == HSTART);
         busy_q       <= (state_n != IDLE);
         mcu_done_q   <= mcu_done_n;
         frame_done_q <= frame_done_n;
         huff_err_q   <= huff_err_n;
         is_lum_q     <= is_lum_n;
         comp_q       <= comp_n;
         row_q        <= row_out_n;
      end
   end

   assign bus.blk_ready           = blk_ready_q;
   assign bus.input_enable        = blk_ready_q & bus.blk_valid;
   assign bus.dct_enable          = dct_en_q;
   assign bus.dct_end_enable      = capt_q;
   assign bus.zigzag_input_enable = zzin_q;
   assign bus.zigag_enable        = zz_q;
   assign bus.Huffman_start       = hstart_q;
   assign bus.matrix_row          = row_q;
   assign bus.is_luminance        = is_lum_q;
   assign bus.comp_id             = comp_q;
   assign bus.busy                = busy_q;
   assign bus.mcu_done            = mcu_done_q;
   assign bus.frame_done          = frame_done_q;
   assign bus.huff_err            = huff_err_q;

endmodule
